conv_sched: RTL and testbench
=============================

CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 Parameters SHALL be: ADDRX=5, x address width; ADDRF=4, filter address width; LENX=32, input length; LENF=9, filter taps; P=3, parallel MAC lanes.
REQ-002 Derived constants SHALL be: SIZE=LENX-LENF+1 (24), outputs per frame; NGRP=ceil(SIZE/P) (8), lane groups per frame.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  in  1  input buffer full, frame ready; sampled only in IDLE.
REQ-006 out_ready  in  1  output buffer can accept one group of P results.
REQ-007 addr_x  out  P*ADDRX  x read addresses; lane j at bits [j*ADDRX +: ADDRX].
REQ-008 addr_f  out  ADDRF  filter ROM read address, shared by all lanes.
REQ-009 clr_acc  out  1  clear all lane accumulators.
REQ-010 en_acc  out  1  accumulate the product of current memory outputs.
REQ-011 valid_op  out  1  one-cycle strobe: write lane accumulators to output buffer.
REQ-012 start_addr  out  ADDRX  output index of lane 0 for the group being written.
REQ-013 lane_mask  out  P  bit j=1 when lane j's output index is < SIZE.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 conv_done  out  1  one-cycle pulse after a frame's last group is written.

Function
REQ-016 FSM states SHALL be IDLE, CLR, RUN, DRAIN, WRITE, WAIT, DONE.
REQ-017 IDLE -> CLR when start=1 and out_ready=1; IDLE -> WAIT when start=1 and out_ready=0; otherwise stay in IDLE.
REQ-018 CLR SHALL assert clr_acc for exactly one cycle, set tap k=0, and go to RUN.
REQ-019 RUN SHALL issue tap k per cycle for k=0..LENF-1: addr_f=k and lane j addr_x=min(g*P+j+k, LENX-1), where g is the group index.
REQ-020 en_acc SHALL be a registered copy of "RUN address issued", so it is high one cycle after each issue, matching the 1-cycle memory read latency.
REQ-021 After k=LENF-1 the FSM SHALL go to DRAIN for one cycle, covering en_acc for the last tap.
REQ-022 WRITE SHALL hold for one cycle with valid_op=1, start_addr=g*P and lane_mask per REQ-013.
REQ-023 From WRITE: if g=NGRP-1, go to DONE; else g increments and the FSM goes to CLR when out_ready=1, else to WAIT.
REQ-024 WAIT SHALL go to CLR when out_ready=1 and issue no addresses or strobes while waiting.
REQ-025 DONE SHALL pulse conv_done for one cycle, clear g, and return to IDLE.
REQ-026 Latency SHALL be LENF+3 cycles per group (12) with no backpressure, and 96 cycles from CLR entry to DONE per frame.
REQ-027 addr_x and addr_f SHALL read 0 outside RUN; clr_acc, en_acc (except the trailing DRAIN pulse), valid_op and conv_done SHALL be 0 outside their states.
REQ-028 clr_acc and en_acc SHALL never be high in the same cycle.
REQ-029 start asserted while busy=1 SHALL be ignored; it is not queued.
REQ-030 The address clamp SHALL apply only to lanes masked off; in-range lanes never exceed LENX-1.
REQ-031 out_ready SHALL be ignored in CLR, RUN, DRAIN and WRITE; a started group always completes.

Reset
REQ-032 reset=0 SHALL immediately force IDLE with g=0, k=0 and all outputs 0, including mid-RUN; an in-flight group is discarded without valid_op.
REQ-033 On reset release the block SHALL wait in IDLE for start.

Verification
REQ-034 Stimulus: start=1 and out_ready=1 held. Required: clr_acc at cycle 1; addr_f 0..8; lane addr_x {0,1,2}..{8,9,10} in group 0; valid_op with start_addr 0 and lane_mask 3'b111 at cycle 12; conv_done one cycle after the group-7 write (start_addr 21).
REQ-035 Stimulus: group-7 RUN tap 8. Required: addr_x={29,30,31}, with no clamping.
REQ-036 Stimulus: out_ready=0 for 5 cycles after the group-2 write. Required: FSM in WAIT, no strobes, and group 3 CLR on the first cycle out_ready=1.
REQ-037 Stimulus: reset=0 during group 4 RUN at k=4. Required: all outputs 0 asynchronously, no valid_op, and a following start restarts at group 0.
REQ-038 Stimulus: start pulsed mid-frame. Required: no effect, and exactly 8 valid_op strobes per frame.
REQ-039 Stimulus: LENX=31 build (SIZE=23). Required: last group has lane_mask 3'b011 and lane 2 address clamped at 30.

Source files
------------

// File: rtl/conv_sched_if.sv
// ---------------------------------------------------------------------------
// conv_sched_if
// Bundles the handshake and memory-control signals that connect the
// convolution scheduler to the testbench or to the surrounding datapath.
//
// Signals are named from the scheduler's point of view:
//   i_start       frame ready in the input buffer
//   i_out_ready   output buffer can take one group of P results
//   o_addr_x      P packed x read addresses, lane j at [j*ADDRX +: ADDRX]
//   o_addr_f      filter ROM address shared by all lanes
//   o_clr_acc     clear lane accumulators
//   o_en_acc      accumulate current memory outputs
//   o_valid_op    write lane accumulators to the output buffer
//   o_start_addr  output index of lane 0 for the group being written
//   o_lane_mask   lanes whose output index is inside the frame
//   o_busy        scheduler is not idle
//   o_conv_done   one-cycle pulse after the last group of a frame
//
// Modports:
//   master  drives start/out_ready and observes the scheduler outputs
//   slave   the scheduler itself
// ---------------------------------------------------------------------------
interface conv_sched_if #(
  parameter int ADDRX = 5,
  parameter int ADDRF = 4,
  parameter int P     = 3
);
  logic                 i_start;
  logic                 i_out_ready;
  logic [P*ADDRX-1:0]   o_addr_x;
  logic [ADDRF-1:0]     o_addr_f;
  logic                 o_clr_acc;
  logic                 o_en_acc;
  logic                 o_valid_op;
  logic [ADDRX-1:0]     o_start_addr;
  logic [P-1:0]         o_lane_mask;
  logic                 o_busy;
  logic                 o_conv_done;

  modport master (
    output i_start, i_out_ready,
    input  o_addr_x, o_addr_f, o_clr_acc, o_en_acc, o_valid_op,
           o_start_addr, o_lane_mask, o_busy, o_conv_done
  );

  modport slave (
    input  i_start, i_out_ready,
    output o_addr_x, o_addr_f, o_clr_acc, o_en_acc, o_valid_op,
           o_start_addr, o_lane_mask, o_busy, o_conv_done
  );
endinterface

// File: rtl/conv_sched.sv
// ---------------------------------------------------------------------------
// conv_sched
// Address and control sequencer for a P-lane 1-D convolution engine.
// A frame of LENX inputs produces SIZE = LENX-LENF+1 outputs, computed in
// NGRP groups of P lanes. For each group the scheduler clears the lane
// accumulators, streams LENF taps of x/filter addresses, waits one cycle for
// the last memory read to land, then strobes the group into the output
// buffer. Backpressure is honoured only between groups.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    conv_sched_if slave modport (see interface header)
// ---------------------------------------------------------------------------
module conv_sched #(
  parameter int ADDRX = 5,
  parameter int ADDRF = 4,
  parameter int LENX  = 32,
  parameter int LENF  = 9,
  parameter int P     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  conv_sched_if.slave  bus
);

  localparam int SIZE = LENX - LENF + 1;
  localparam int NGRP = (SIZE + P - 1) / P;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int KW   = (LENF > 1) ? $clog2(LENF + 1) : 1;
  // Wide enough for g*P + j + k with generous headroom.
  localparam int IW   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN,
    S_WRITE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [GW-1:0]   r_grp;
  logic [KW-1:0]   r_tap;
  logic            r_enAcc;
  logic            w_lastTap;
  logic            w_lastGrp;
  logic [IW-1:0]   w_outIdx [P];
  logic [IW-1:0]   w_rdIdx  [P];

  assign w_lastTap = (r_tap == KW'(LENF - 1));
  assign w_lastGrp = (r_grp == GW'(NGRP - 1));

  // Per-lane output index (g*P+j) and the x index read for the current tap.
  for (genvar j = 0; j < P; j++) begin : g_lane
    assign w_outIdx[j] = IW'(r_grp) * IW'(P) + IW'(j);
    assign w_rdIdx[j]  = w_outIdx[j] + IW'(r_tap);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Group/tap counters and the accumulate enable. en_acc lags the address
  // issue by one cycle to line up with the synchronous memory read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grp   <= '0;
      r_tap   <= '0;
      r_enAcc <= 1'b0;
    end else begin
      r_enAcc <= (r_state == S_RUN);
      case (r_state)
        S_CLR:   r_tap <= '0;
        S_RUN:   r_tap <= r_tap + 1'b1;
        S_WRITE: if (!w_lastGrp) r_grp <= r_grp + 1'b1;
        S_DONE:  r_grp <= '0;
        default: ;
      endcase
    end
  end

  // Next-state and output decode. Everything defaults to zero so that any
  // state not explicitly driving an output leaves it low.
  always_comb begin
    w_nextState      = r_state;
    bus.o_addr_x     = '0;
    bus.o_addr_f     = '0;
    bus.o_clr_acc    = 1'b0;
    bus.o_en_acc     = r_enAcc;
    bus.o_valid_op   = 1'b0;
    bus.o_start_addr = '0;
    bus.o_lane_mask  = '0;
    bus.o_busy       = (r_state != S_IDLE);
    bus.o_conv_done  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_nextState = bus.i_out_ready ? S_CLR : S_WAIT;
        end
      end
      S_CLR: begin
        bus.o_clr_acc = 1'b1;
        w_nextState   = S_RUN;
      end
      S_RUN: begin
        bus.o_addr_f = ADDRF'(r_tap);
        // Only lanes past the end of the frame can run off the input; clamp
        // them to the last sample so the read stays in bounds.
        for (int j = 0; j < P; j++) begin
          if (w_rdIdx[j] > IW'(LENX - 1)) begin
            bus.o_addr_x[j*ADDRX +: ADDRX] = ADDRX'(LENX - 1);
          end else begin
            bus.o_addr_x[j*ADDRX +: ADDRX] = w_rdIdx[j][ADDRX-1:0];
          end
        end
        if (w_lastTap) begin
          w_nextState = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_nextState = S_WRITE;
      end
      S_WRITE: begin
        bus.o_valid_op   = 1'b1;
        bus.o_start_addr = w_outIdx[0][ADDRX-1:0];
        for (int j = 0; j < P; j++) begin
          bus.o_lane_mask[j] = (w_outIdx[j] < IW'(SIZE));
        end
        if (w_lastGrp) begin
          w_nextState = S_DONE;
        end else begin
          w_nextState = bus.i_out_ready ? S_CLR : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.i_out_ready) begin
          w_nextState = S_CLR;
        end
      end
      S_DONE: begin
        bus.o_conv_done = 1'b1;
        w_nextState     = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_sched.sv
// ---------------------------------------------------------------------------
// tb_conv_sched
// Directed bench for conv_sched. Two instances run in lockstep from the same
// inputs: dutA with LENX=32 (SIZE=24) and dutB with LENX=31 (SIZE=23), so the
// short-frame clamp and mask behaviour is observed alongside the full frame.
// ---------------------------------------------------------------------------
module tb_conv_sched;

  logic clk;
  logic rst_n;

  int checkCount  = 0;
  int errorCount  = 0;
  int strobeCount = 0;

  conv_sched_if #(.ADDRX(5), .ADDRF(4), .P(3)) ifA ();
  conv_sched_if #(.ADDRX(5), .ADDRF(4), .P(3)) ifB ();

  conv_sched #(.ADDRX(5), .ADDRF(4), .LENX(32), .LENF(9), .P(3)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifA)
  );

  conv_sched #(.ADDRX(5), .ADDRF(4), .LENX(31), .LENF(9), .P(3)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case the flow ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: count it and report any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic startVal, input logic readyVal);
    ifA.i_start     = startVal;
    ifB.i_start     = startVal;
    ifA.i_out_ready = readyVal;
    ifB.i_out_ready = readyVal;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (ifA.o_valid_op) strobeCount++;
  endtask

  // Lane j reads x[g*3+j+k], clamped to the last sample of the frame.
  function automatic logic [14:0] expAddrX(input int lenx, input int g, input int k);
    logic [14:0] r;
    int v;
    r = '0;
    for (int j = 0; j < 3; j++) begin
      v = g * 3 + j + k;
      if (v > lenx - 1) v = lenx - 1;
      r[j*5 +: 5] = 5'(v);
    end
    return r;
  endfunction

  function automatic logic [2:0] expMask(input int size, input int g);
    logic [2:0] m;
    for (int j = 0; j < 3; j++) m[j] = ((g * 3 + j) < size);
    return m;
  endfunction

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " addr_x"},     32'(ifA.o_addr_x), 0);
    checkOutput({tag, " addr_f"},     32'(ifA.o_addr_f), 0);
    checkOutput({tag, " clr_acc"},    32'(ifA.o_clr_acc), 0);
    checkOutput({tag, " en_acc"},     32'(ifA.o_en_acc), 0);
    checkOutput({tag, " valid_op"},   32'(ifA.o_valid_op), 0);
    checkOutput({tag, " start_addr"}, 32'(ifA.o_start_addr), 0);
    checkOutput({tag, " lane_mask"},  32'(ifA.o_lane_mask), 0);
    checkOutput({tag, " conv_done"},  32'(ifA.o_conv_done), 0);
  endtask

  task automatic runGroup(input int g, input int abortK, input bit holdStart,
                          output bit aborted);
    aborted = 1'b0;
    stepCycle();
    checkOutput($sformatf("g%0d CLR clr_acc", g), 32'(ifA.o_clr_acc), 1);
    checkOutput($sformatf("g%0d CLR en_acc", g), 32'(ifA.o_en_acc), 0);
    checkOutput($sformatf("g%0d CLR B clr_acc", g), 32'(ifB.o_clr_acc), 1);
    if (!holdStart) applyStimulus(1'b0, ifA.i_out_ready);

    for (int k = 0; k < 9; k++) begin
      stepCycle();
      checkOutput($sformatf("g%0d k%0d addr_f", g, k), 32'(ifA.o_addr_f), 32'(k));
      checkOutput($sformatf("g%0d k%0d addr_x", g, k), 32'(ifA.o_addr_x),
                  32'(expAddrX(32, g, k)));
      checkOutput($sformatf("g%0d k%0d B addr_x", g, k), 32'(ifB.o_addr_x),
                  32'(expAddrX(31, g, k)));
      checkOutput($sformatf("g%0d k%0d en_acc", g, k), 32'(ifA.o_en_acc),
                  (k > 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("g%0d k%0d clr_acc", g, k), 32'(ifA.o_clr_acc), 0);
      if (g == 7 && k == 8) begin
        checkOutput("g7 k8 addr_x no clamp", 32'(ifA.o_addr_x),
                    32'({5'd31, 5'd30, 5'd29}));
        checkOutput("g7 k8 B lane2 clamp", 32'(ifB.o_addr_x[14:10]), 30);
      end
      if (k == abortK) begin
        #2;
        rst_n = 1'b0;
        #1;
        checkQuiet("async reset");
        checkOutput("async reset busy", 32'(ifA.o_busy), 0);
        checkOutput("async reset B busy", 32'(ifB.o_busy), 0);
        stepCycle();
        checkOutput("in reset valid_op", 32'(ifA.o_valid_op), 0);
        stepCycle();
        checkOutput("in reset busy", 32'(ifA.o_busy), 0);
        rst_n = 1'b1;
        aborted = 1'b1;
        return;
      end
    end

    stepCycle();
    checkOutput($sformatf("g%0d DRAIN en_acc", g), 32'(ifA.o_en_acc), 1);
    checkOutput($sformatf("g%0d DRAIN addr_x", g), 32'(ifA.o_addr_x), 0);
    checkOutput($sformatf("g%0d DRAIN addr_f", g), 32'(ifA.o_addr_f), 0);
    checkOutput($sformatf("g%0d DRAIN valid_op", g), 32'(ifA.o_valid_op), 0);

    stepCycle();
    checkOutput($sformatf("g%0d WRITE valid_op", g), 32'(ifA.o_valid_op), 1);
    checkOutput($sformatf("g%0d WRITE start_addr", g), 32'(ifA.o_start_addr), 32'(g * 3));
    checkOutput($sformatf("g%0d WRITE lane_mask", g), 32'(ifA.o_lane_mask),
                32'(expMask(24, g)));
    checkOutput($sformatf("g%0d WRITE B lane_mask", g), 32'(ifB.o_lane_mask),
                32'(expMask(23, g)));
    checkOutput($sformatf("g%0d WRITE en_acc", g), 32'(ifA.o_en_acc), 0);
    if (g == 0) checkOutput("g0 WRITE mask full", 32'(ifA.o_lane_mask), 32'b111);
    if (g == 7) checkOutput("g7 WRITE B mask", 32'(ifB.o_lane_mask), 32'b011);
  endtask

  task automatic runFrame(input int waitAfterGrp, input int abortGrp, input int abortK,
                          input bit holdStart, output bit aborted);
    bit ab;
    strobeCount = 0;
    aborted = 1'b0;
    for (int g = 0; g < 8; g++) begin
      runGroup(g, (g == abortGrp) ? abortK : -1, holdStart, ab);
      if (ab) begin
        aborted = 1'b1;
        return;
      end
      if (g == waitAfterGrp) begin
        applyStimulus(ifA.i_start, 1'b0);
        for (int i = 0; i < 5; i++) begin
          stepCycle();
          checkQuiet($sformatf("WAIT%0d", i));
          checkOutput($sformatf("WAIT%0d busy", i), 32'(ifA.o_busy), 1);
          if (i == 1) applyStimulus(1'b1, 1'b0);
          if (i == 2) applyStimulus(1'b0, 1'b0);
          if (i == 4) applyStimulus(1'b0, 1'b1);
        end
      end
    end
    stepCycle();
    checkOutput("DONE conv_done", 32'(ifA.o_conv_done), 1);
    checkOutput("DONE B conv_done", 32'(ifB.o_conv_done), 1);
    checkOutput("DONE valid_op", 32'(ifA.o_valid_op), 0);
    checkOutput("DONE busy", 32'(ifA.o_busy), 1);
    applyStimulus(1'b0, 1'b1);
    stepCycle();
    checkOutput("post DONE busy", 32'(ifA.o_busy), 0);
    checkOutput("post DONE conv_done", 32'(ifA.o_conv_done), 0);
    checkOutput("frame strobes", 32'(strobeCount), 8);
  endtask

  initial begin
    bit aborted;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkQuiet("reset");
    checkOutput("reset busy", 32'(ifA.o_busy), 0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("idle busy", 32'(ifA.o_busy), 0);

    // Frame 1: start and out_ready held high throughout.
    applyStimulus(1'b1, 1'b1);
    runFrame(-1, -1, -1, 1'b1, aborted);

    // Frame 2: backpressure after group 2, with a start pulse while waiting.
    applyStimulus(1'b1, 1'b1);
    runFrame(2, -1, -1, 1'b0, aborted);

    // Frame 3: reset during group 4 tap 4, then restart from group 0.
    applyStimulus(1'b1, 1'b1);
    runFrame(-1, 4, 4, 1'b0, aborted);
    checkOutput("abort taken", 32'(aborted), 1);
    checkOutput("abort strobes", 32'(strobeCount), 4);
    stepCycle();
    checkOutput("post reset idle busy", 32'(ifA.o_busy), 0);
    applyStimulus(1'b1, 1'b1);
    runGroup(0, -1, 1'b0, aborted);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
